// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender (sign / zero / upper / branch)
// with a registered output stage and a one-entry skid buffer. The in_ready
// output comes straight from a register, so a stall on the output side never
// feeds a combinational path back into decode.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int EXT_W = OUT_W - IN_W;

    // The state encoding is {skid_valid, out_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              skid_valid;
    logic [OUT_W-1:0]  skid_data;
    logic [TAG_W-1:0]  skid_tag;
    logic [OUT_W-1:0]  sext;
    logic [OUT_W-1:0]  ext_data;
    logic              accept;
    logic              out_fire;
    logic              load_out_from_in;
    logic              load_out_from_skid;
    logic              load_skid;

    // Extend the incoming immediate according to the requested mode.
    always_comb begin
        sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        ext_data = sext;
        case (in_mode)
            2'b00:   ext_data = sext;
            2'b01:   ext_data = {{EXT_W{1'b0}}, in_imm};
            2'b10:   ext_data = {in_imm, {EXT_W{1'b0}}};
            default: ext_data = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and register-load controls.
    always_comb begin
        skid_valid         = state[1];
        out_valid          = state[0];
        in_ready           = ~skid_valid;
        accept             = in_valid & in_ready & ~rst & ~flush;
        out_fire           = out_valid & out_ready;
        state_nxt          = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt        = ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_fire) begin
                    state_nxt        = ONE;
                    load_out_from_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nxt          = ONE;
                    load_out_from_skid = ~flush;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // Output and skid data registers; they only ever hold final results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (load_out_from_in) begin
                out_data <= ext_data;
                out_tag  <= in_tag;
            end else if (load_out_from_skid) begin
                out_data <= skid_data;
                out_tag  <= skid_tag;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_tag  <= in_tag;
            end
        end
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the pipelined MIPS datapath. It takes an IN_W-bit immediate and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-load, or branch-offset (sign-extend then ×4). The block sits between instruction decode and the execute-stage operand mux. It uses a valid/ready handshake with a registered output stage plus a one-entry skid buffer, so stalls from execute never create a combinational ready path back into decode. A flush input discards in-flight results on branch mispredict.

## Interface
- IN_W, 16, immediate input width; must satisfy 1 ≤ IN_W < OUT_W − 1.
- OUT_W, 32, extended output width.
- TAG_W, 5, width of a sideband tag (e.g. destination register number) carried unchanged alongside the data.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- flush  in  1  synchronous discard of all held beats.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat; equals NOT skid_valid (register-driven, no combinational path from out_ready).
- in_imm  in  IN_W  immediate field.
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  out_data/out_tag hold a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Mode 00: out = {(OUT_W−IN_W){imm[IN_W−1]}, imm}.
- Mode 01: out = {(OUT_W−IN_W){0}, imm}.
- Mode 10: out = imm << (OUT_W−IN_W); low bits are zero.
- Mode 11: out = sign-extend(imm) << 2; the top 2 bits of the sign-extended value are dropped, and bits [1:0] are 0.
- Extension is computed combinationally on in_imm and registered at acceptance. Stored registers hold final results only.
- Storage: output register (out_valid, out_data, out_tag) plus skid register (skid_valid, skid_data, skid_tag).
- States, encoded by {skid_valid, out_valid}:
  - EMPTY (00): accept → ONE.
  - ONE (01):
    - out fire without accept → EMPTY.
    - accept with out fire → ONE (new beat loaded into the output register).
    - accept without out fire → TWO (new beat goes to skid).
  - TWO (11): in_ready = 0.
    - out fire → ONE; the output register loads from skid.
    - No out fire → stay in TWO.
- accept = in_valid & in_ready & !rst & !flush.
- out fire = out_valid & out_ready.
- Ordering is strictly FIFO. No beat is lost or duplicated.
- While out_valid = 1 and out_ready = 0, out_data and out_tag are held stable.
- Flush: next state is EMPTY. A beat presented in the flush cycle is discarded, even if in_ready = 1. An out fire in the flush cycle still counts as delivered to the consumer.
- Reset: out_valid = 0, skid_valid = 0 (so in_ready = 1), out_data = 0, out_tag = 0, skid registers = 0. Reset dominates flush and in_valid.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on out_* after edge N.
- Throughput is 1 beat/cycle while out_ready = 1.
- When out_ready falls, one additional beat is absorbed into skid. in_ready drops in the cycle after that absorption.
- in_ready returns to 1 in the cycle after the first out fire from TWO.
- Reset mid-stream: all held beats are lost. Outputs read their reset values in the cycle after the rst edge.
- Simultaneous accept and out fire in ONE: no bubble, and out_valid stays 1.

## Test plan
- Mode sweep, with out_ready = 1 and IN_W = 16, OUT_W = 32:
  - imm 0x8001 mode 00 → 0xFFFF8001.
  - imm 0x8001 mode 01 → 0x00008001.
  - imm 0x1234 mode 10 → 0x12340000.
  - imm 0xFFFF mode 11 → 0xFFFFFFFC.
  - imm 0x4000 mode 11 → 0x00010000.
  - Each result appears 1 cycle after acceptance, with the tag echoed.
- Back-pressure: stream tags 1..6 continuously. Hold out_ready = 0 for 4 cycles starting at the first out_valid.
  - in_ready drops after exactly 2 beats are held.
  - Release out_ready: tags arrive in order 1..6 with no gaps or duplicates, and out_data is stable during the stall.
- Full-throughput: 100 random beats with out_ready = 1 → 100 outputs, each one cycle after its input; in_ready stays 1 throughout.
- Flush in TWO, with in_valid = 1 in the same cycle → next cycle out_valid = 0 and in_ready = 1; the flush-cycle beat never appears at the output.
- Reset mid-stall (state TWO), then assert rst for 1 cycle → out_valid = 0, out_data = 0, in_ready = 1. The next accepted beat (imm 0x0005 mode 00) yields 0x00000005 after 1 cycle.
- Parameter variant IN_W = 8, OUT_W = 16:
  - imm 0x80 mode 00 → 0xFF80.
  - imm 0x80 mode 10 → 0x8000.
  - imm 0xFF mode 11 → 0xFFFC.
